// File: rtl/led_blink_sequencer.sv
// Burst LED sequencer: N ON/OFF pulses followed by a GAP, then a one-cycle done.
// Optional abort input is enabled by defining LED_SEQ_ABORT_EN.
module led_blink_sequencer #(
   parameter int TICK_DIV  = 5000,
   parameter int ON_TICKS  = 4,
   parameter int OFF_TICKS = 4,
   parameter int GAP_TICKS = 16,
   parameter int CNT_W     = 4
) (
   input  logic             CLOCK_50,
   input  logic             reset,
   input  logic             cmd_valid,
   input  logic [CNT_W-1:0] cmd_count,
`ifdef LED_SEQ_ABORT_EN
   input  logic             abort,
`endif
   output logic             cmd_ready,
   output logic             busy,
   output logic             done,
   output logic             LED,
   output logic [1:0]       dbg_state_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ON   = 2'd1;
   localparam logic [1:0] S_OFF  = 2'd2;
   localparam logic [1:0] S_GAP  = 2'd3;

   localparam int MAX_OG    = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
   localparam int MAX_TICKS = (MAX_OG > GAP_TICKS) ? MAX_OG : GAP_TICKS;
   localparam int TMR_W     = $clog2(MAX_TICKS + 1);
   localparam int PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
   localparam logic [TMR_W-1:0] ON_LAST  = TMR_W'(ON_TICKS - 1);
   localparam logic [TMR_W-1:0] OFF_LAST = TMR_W'(OFF_TICKS - 1);
   localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP_TICKS - 1);

   logic [1:0]       state_q, state_d;
   logic             led_q, led_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [PRE_W-1:0] presc_q, presc_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;

   logic             tick;
   logic             phase_end;
   logic             abort_req;
   logic [TMR_W-1:0] phase_last;

`ifdef LED_SEQ_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   assign busy        = (state_q != S_IDLE);
   assign cmd_ready   = (state_q == S_IDLE);
   assign done        = done_q;
   assign LED         = led_q;
   assign dbg_state_o = state_q;

   assign tick = busy && (presc_q == PRE_LAST);

   always_comb begin
      phase_last = GAP_LAST;
      case (state_q)
         S_ON:    phase_last = ON_LAST;
         S_OFF:   phase_last = OFF_LAST;
         default: phase_last = GAP_LAST;
      endcase
   end

   // Timer counts completed ticks within the phase; the phase ends on its last tick edge.
   assign phase_end = tick && (tmr_q == phase_last);

   always_comb begin
      state_d = state_q;
      led_d   = led_q;
      done_d  = 1'b0;
      rem_d   = rem_q;
      presc_d = presc_q;
      tmr_d   = tmr_q;

      if (busy) begin
         if (tick) begin
            presc_d = '0;
            tmr_d   = tmr_q + 1'b1;
         end else begin
            presc_d = presc_q + 1'b1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               presc_d = '0;
               tmr_d   = '0;
               if (cmd_count == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = S_ON;
                  led_d   = 1'b1;
                  rem_d   = cmd_count;
               end
            end
         end
         S_ON: begin
            if (phase_end) begin
               state_d = S_OFF;
               led_d   = 1'b0;
               rem_d   = rem_q - 1'b1;
               tmr_d   = '0;
            end
         end
         S_OFF: begin
            if (phase_end) begin
               tmr_d = '0;
               if (rem_q != '0) begin
                  state_d = S_ON;
                  led_d   = 1'b1;
               end else begin
                  state_d = S_GAP;
               end
            end
         end
         S_GAP: begin
            if (phase_end) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
               tmr_d   = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            led_d   = 1'b0;
         end
      endcase

      // Abort overrides any phase advance decided above.
      if (abort_req && busy) begin
         state_d = S_IDLE;
         led_d   = 1'b0;
         done_d  = 1'b1;
         rem_d   = '0;
         presc_d = '0;
         tmr_d   = '0;
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         led_q   <= 1'b0;
         done_q  <= 1'b0;
         rem_q   <= '0;
         presc_q <= '0;
         tmr_q   <= '0;
      end else begin
         state_q <= state_d;
         led_q   <= led_d;
         done_q  <= done_d;
         rem_q   <= rem_d;
         presc_q <= presc_d;
         tmr_q   <= tmr_d;
      end
   end

endmodule

// File: tb/tb_led_blink_sequencer.sv
// Directed bench for led_blink_sequencer with TICK_DIV=4, ON=2, OFF=2, GAP=3 ticks.
// Pulse = 8 cycles high + 8 low, gap = 12 cycles; abort steps need LED_SEQ_ABORT_EN.
module tb_led_blink_sequencer;

   localparam int ON_CYC  = 8;
   localparam int PER_CYC = 16;
   localparam int GAP_CYC = 12;

   logic       clk;
   logic       reset;
   logic       cmd_valid;
   logic [3:0] cmd_count;
   logic       abort;
   logic       cmd_ready;
   logic       busy;
   logic       done;
   logic       led;
   logic [1:0] dbg_state;

   int checks = 0;
   int errors = 0;

   led_blink_sequencer #(
      .TICK_DIV (4),
      .ON_TICKS (2),
      .OFF_TICKS(2),
      .GAP_TICKS(3),
      .CNT_W    (4)
   ) dut (
      .CLOCK_50   (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_count  (cmd_count),
`ifdef LED_SEQ_ABORT_EN
      .abort      (abort),
`endif
      .cmd_ready  (cmd_ready),
      .busy       (busy),
      .done       (done),
      .LED        (led),
      .dbg_state_o(dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue a command at a negedge and check every cycle until one cycle past done.
   task automatic run_burst(input int n, input int inject_k);
      int len;
      len = n * PER_CYC + GAP_CYC;
      cmd_valid = 1'b1;
      cmd_count = 4'(n);
      check("ready_before_accept", 32'(cmd_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int k = 0; k <= len + 1; k++) begin
         if (k > 0) @(negedge clk);
         if (k == inject_k) begin
            cmd_valid = 1'b1;
            cmd_count = 4'd5;
         end else if (k == inject_k + 1) begin
            cmd_valid = 1'b0;
         end
         if (k < len) begin
            check($sformatf("n%0d_led_k%0d", n, k), 32'(led),
                  32'((k < n * PER_CYC) && ((k % PER_CYC) < ON_CYC)));
            check($sformatf("n%0d_busy_k%0d", n, k), 32'(busy), 32'd1);
            check($sformatf("n%0d_done_k%0d", n, k), 32'(done), 32'd0);
         end else if (k == len) begin
            check($sformatf("n%0d_done_end", n), 32'(done), 32'd1);
            check($sformatf("n%0d_busy_end", n), 32'(busy), 32'd0);
            check($sformatf("n%0d_ready_end", n), 32'(cmd_ready), 32'd1);
            check($sformatf("n%0d_led_end", n), 32'(led), 32'd0);
         end else begin
            check($sformatf("n%0d_done_after", n), 32'(done), 32'd0);
            check($sformatf("n%0d_busy_after", n), 32'(busy), 32'd0);
         end
      end
   endtask

   initial begin
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_count = 4'd0;
      abort     = 1'b0;
      #1;
      check("rst_led", 32'(led), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_ready", 32'(cmd_ready), 32'd1);
      check("rst_state", 32'(dbg_state), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Reset in the middle of the second pulse clears outputs before the next edge.
      cmd_valid = 1'b1;
      cmd_count = 4'd3;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int k = 1; k <= 20; k++) @(negedge clk);
      check("mid_led_high", 32'(led), 32'd1);
      reset = 1'b1;
      #1;
      check("mid_rst_led", 32'(led), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_ready", 32'(cmd_ready), 32'd1);
      check("mid_rst_state", 32'(dbg_state), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_idle_led", 32'(led), 32'd0);
      check("post_rst_idle_busy", 32'(busy), 32'd0);

      // Three pulses: done 60 cycles after accept.
      run_burst(3, -10);

      // Zero count: immediate done, nothing else moves.
      cmd_valid = 1'b1;
      cmd_count = 4'd0;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("zero_done", 32'(done), 32'd1);
      check("zero_busy", 32'(busy), 32'd0);
      check("zero_led", 32'(led), 32'd0);
      check("zero_ready", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      check("zero_done_clr", 32'(done), 32'd0);
      check("zero_busy_after", 32'(busy), 32'd0);
      check("zero_led_after", 32'(led), 32'd0);

      // Valid held high with count=1: bursts repeat every 29 cycles.
      cmd_valid = 1'b1;
      cmd_count = 4'd1;
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 58; k++) begin
         if (k > 0) @(negedge clk);
         check($sformatf("b2b_led_k%0d", k), 32'(led), 32'((k % 29) < ON_CYC));
         check($sformatf("b2b_done_k%0d", k), 32'(done), 32'((k % 29) == 28));
         check($sformatf("b2b_busy_k%0d", k), 32'(busy), 32'((k % 29) != 28));
      end
      cmd_valid = 1'b0;
      @(negedge clk);
      check("b2b_stop_busy", 32'(busy), 32'd0);
      check("b2b_stop_done", 32'(done), 32'd0);

      // Command pulsed mid-burst must not disturb the running burst.
      run_burst(3, 10);

      // Maximum count runs all fifteen pulses.
      run_burst(15, -10);

`ifdef LED_SEQ_ABORT_EN
      cmd_valid = 1'b1;
      cmd_count = 4'd3;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int k = 1; k <= 18; k++) @(negedge clk);
      check("abort_pre_led", 32'(led), 32'd1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_led", 32'(led), 32'd0);
      check("abort_done", 32'(done), 32'd1);
      check("abort_ready", 32'(cmd_ready), 32'd1);
      check("abort_busy", 32'(busy), 32'd0);
      @(negedge clk);
      check("abort_done_clr", 32'(done), 32'd0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_idle_done", 32'(done), 32'd0);
      check("abort_idle_busy", 32'(busy), 32'd0);
      run_burst(1, -10);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
